mult_div_seq: RTL and testbench
===============================

MULT_DIV_SEQ -- requirements
Module: mult_div_seq

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-low; 0 forces reset state immediately, independent of clk.
REQ-003 start  in  1  operation request; sampled only in IDLE.
REQ-004 op  in  1  0 = signed MULT, 1 = signed DIV.
REQ-005 a_in  in  32  multiplicand / dividend (register A output).
REQ-006 b_in  in  32  multiplier / divisor (register B output).
REQ-007 hi_out  out  32  MULT: product[63:32]; DIV: remainder; feeds HiReg data input.
REQ-008 lo_out  out  32  MULT: product[31:0]; DIV: quotient; feeds LoReg data input.
REQ-009 busy  out  1  high in RUN and DONE states.
REQ-010 done  out  1  one-cycle pulse; hi_out/lo_out valid in that cycle; control unit asserts HiWrite/LoWrite on it.
REQ-011 div_zero  out  1  one-cycle pulse with done when DIV and b_in == 0.

Function
REQ-012 FSM states: IDLE, RUN, DONE; no other reachable state.
REQ-013 IDLE & start=1: latch op, a_in, b_in into internal registers; load iteration counter with 31; go to RUN.
REQ-014 IDLE & start=1 & op=1 & b_in=0: go directly to DONE with div_zero=1; hi_out/lo_out keep previous values.
REQ-015 RUN: exactly one iteration per cycle; counter decrements; at counter=0 the final iteration completes and state goes to DONE.
REQ-016 Latency: start sampled at edge k -> done=1 during cycle following edge k+32 (32 RUN cycles); div-by-zero -> done during cycle after edge k.
REQ-017 DONE: done=1 for exactly one cycle, then IDLE unconditionally; start in DONE is ignored.
REQ-018 start in RUN or DONE is ignored; a_in/b_in changes after acceptance do not affect the result.
REQ-019 MULT: signed 32x32 -> 64-bit two's-complement product, radix-2 Booth, 64-bit accumulator plus 1-bit Booth guard.
REQ-020 DIV: signed restoring division on magnitudes; quotient truncates toward zero; remainder takes sign of dividend; |remainder| < |divisor|.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF: lo_out=0x80000000, hi_out=0x00000000, no div_zero.
REQ-022 hi_out/lo_out registered; update only on the edge entering DONE (non-zero cases); hold value otherwise, including during the next RUN.
REQ-023 done, div_zero, busy are decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-024 reset=0 from any state, including mid-RUN: state=IDLE, counter=0, all internal operand/accumulator registers=0.
REQ-025 Reset values: hi_out=0, lo_out=0, busy=0, done=0, div_zero=0.
REQ-026 Operation aborted by reset produces no done pulse; first start after reset release is accepted normally.

Structure
REQ-027 Shared package muldiv_pkg holds: state enum (IDLE, RUN, DONE), op encoding constants (OP_MULT=0, OP_DIV=1), MD_WIDTH=32, MD_ITER=32.
REQ-028 One combinational sub-module div_restore_step: inputs partial remainder (33 b), divisor magnitude (32 b), next dividend bit; outputs new remainder and quotient bit; instantiated once in mult_div_seq.
REQ-029 Booth step, counter, sign correction and FSM live in mult_div_seq; target 120-400 lines RTL total.

Verification
REQ-030 MULT a=7, b=-3 (0xFFFFFFFD) -> done 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-031 DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); div_zero=0.
REQ-032 DIV a=100, b=0 -> done and div_zero high in cycle after start edge; hi/lo unchanged from previous result.
REQ-033 MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000; then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 Start MULT 5x5, assert reset=0 at RUN cycle 10 -> outputs zero immediately (async), no done; after release MULT 3x4 -> lo=12, hi=0.
REQ-035 Pulse start during RUN and during DONE with different operands -> ignored; single done, result of original operands; busy low the cycle after done.

Source files
------------

// File: rtl/mult_div_seq_pkg.sv
// Shared types and constants for the sequential signed multiply/divide unit.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITER  = 32;
  localparam int CNT_W    = $clog2(MD_ITER);

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Absolute value of a two's-complement word; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude 2^31.
  function automatic logic [MD_WIDTH-1:0] magnitude(input logic [MD_WIDTH-1:0] v);
    return v[MD_WIDTH-1] ? ({MD_WIDTH{1'b0}} - v) : v;
  endfunction

endpackage

// File: rtl/mult_div_seq_if.sv
// Operand/result bundle between the control unit (master) and mult_div_seq (slave).
interface mult_div_seq_if;
  import muldiv_pkg::*;

  logic                start;
  logic                op;
  logic [MD_WIDTH-1:0] a_in;
  logic [MD_WIDTH-1:0] b_in;
  logic [MD_WIDTH-1:0] hi_out;
  logic [MD_WIDTH-1:0] lo_out;
  logic                busy;
  logic                done;
  logic                div_zero;

  modport master (
    output start, op, a_in, b_in,
    input  hi_out, lo_out, busy, done, div_zero
  );

  modport slave (
    input  start, op, a_in, b_in,
    output hi_out, lo_out, busy, done, div_zero
  );

endinterface

// File: rtl/mult_div_seq_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when it fits.
module div_restore_step
  import muldiv_pkg::*;
(
  input  logic [MD_WIDTH:0]   prem,
  input  logic [MD_WIDTH-1:0] divisor,
  input  logic                dbit,
  output logic [MD_WIDTH:0]   rem,
  output logic                qbit
);

  // Compare on the full shifted value; the subtraction result always fits in
  // MD_WIDTH+1 bits because the old remainder is smaller than the divisor.
  always_comb begin
    qbit = ({prem, dbit} >= {2'b00, divisor});
    rem  = {prem[MD_WIDTH-1:0], dbit} - (qbit ? {1'b0, divisor} : {(MD_WIDTH+1){1'b0}});
  end

endmodule

// File: rtl/mult_div_seq.sv
// Sequential signed 32x32 multiplier (radix-2 Booth) and restoring divider,
// one iteration per clock, results registered for the Hi/Lo registers.
module mult_div_seq
  import muldiv_pkg::*;
(
  input logic           clk,
  input logic           reset,
  mult_div_seq_if.slave bus
);

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  op_reg, dz_reg, q_neg_reg, r_neg_reg, guard_reg;
  logic [2*MD_WIDTH-1:0] acc_reg;
  logic [MD_WIDTH:0]     rem_reg;
  logic [MD_WIDTH-1:0]   m_reg, hi_reg, lo_reg;

  logic                  dz_start;
  logic [MD_WIDTH:0]     booth_hi_ext, booth_sum;
  logic [2*MD_WIDTH-1:0] booth_next, div_next;
  logic [MD_WIDTH:0]     step_rem;
  logic                  step_q;
  logic [MD_WIDTH-1:0]   q_mag, res_hi, res_lo;

  assign dz_start = (bus.op == OP_DIV) && (bus.b_in == '0);

  div_restore_step u_div_step (
    .prem    (rem_reg),
    .divisor (m_reg),
    .dbit    (acc_reg[MD_WIDTH-1]),
    .rem     (step_rem),
    .qbit    (step_q)
  );

  // Booth step: add/subtract multiplicand into a sign-extended upper half, then
  // arithmetic-shift the whole accumulator right; the guard takes the old LSB.
  always_comb begin
    booth_hi_ext = {acc_reg[2*MD_WIDTH-1], acc_reg[2*MD_WIDTH-1:MD_WIDTH]};
    unique case ({acc_reg[0], guard_reg})
      2'b01:   booth_sum = booth_hi_ext + {m_reg[MD_WIDTH-1], m_reg};
      2'b10:   booth_sum = booth_hi_ext - {m_reg[MD_WIDTH-1], m_reg};
      default: booth_sum = booth_hi_ext;
    endcase
    booth_next = {booth_sum, acc_reg[MD_WIDTH-1:1]};
  end

  // Division step and final result selection with sign correction.
  always_comb begin
    div_next = {acc_reg[2*MD_WIDTH-1:MD_WIDTH], acc_reg[MD_WIDTH-2:0], step_q};
    q_mag    = {acc_reg[MD_WIDTH-2:0], step_q};
    if (op_reg == OP_MULT) begin
      res_hi = booth_next[2*MD_WIDTH-1:MD_WIDTH];
      res_lo = booth_next[MD_WIDTH-1:0];
    end else begin
      res_hi = r_neg_reg ? ({MD_WIDTH{1'b0}} - step_rem[MD_WIDTH-1:0]) : step_rem[MD_WIDTH-1:0];
      res_lo = q_neg_reg ? ({MD_WIDTH{1'b0}} - q_mag) : q_mag;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (bus.start) state_next = dz_start ? DONE : RUN;
      RUN:     if (cnt_reg == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs decoded from registered state only.
  always_comb begin
    bus.busy     = (state_reg != IDLE);
    bus.done     = (state_reg == DONE);
    bus.div_zero = (state_reg == DONE) && dz_reg;
  end

  // Datapath: capture operands on accept, iterate in RUN, register results on the last step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg   <= '0;
      op_reg    <= 1'b0;
      dz_reg    <= 1'b0;
      q_neg_reg <= 1'b0;
      r_neg_reg <= 1'b0;
      guard_reg <= 1'b0;
      acc_reg   <= '0;
      rem_reg   <= '0;
      m_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (bus.start) begin
            op_reg    <= bus.op;
            dz_reg    <= dz_start;
            cnt_reg   <= CNT_W'(MD_ITER - 1);
            guard_reg <= 1'b0;
            rem_reg   <= '0;
            q_neg_reg <= bus.a_in[MD_WIDTH-1] ^ bus.b_in[MD_WIDTH-1];
            r_neg_reg <= bus.a_in[MD_WIDTH-1];
            if (bus.op == OP_MULT) begin
              m_reg   <= bus.a_in;
              acc_reg <= {{MD_WIDTH{1'b0}}, bus.b_in};
            end else begin
              m_reg   <= magnitude(bus.b_in);
              acc_reg <= {{MD_WIDTH{1'b0}}, magnitude(bus.a_in)};
            end
          end
        end
        RUN: begin
          if (cnt_reg != '0) cnt_reg <= cnt_reg - CNT_W'(1);
          if (op_reg == OP_MULT) begin
            acc_reg   <= booth_next;
            guard_reg <= acc_reg[0];
          end else begin
            acc_reg <= div_next;
            rem_reg <= step_rem;
          end
          if (cnt_reg == '0) begin
            hi_reg <= res_hi;
            lo_reg <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi_out = hi_reg;
  assign bus.lo_out = lo_reg;

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq: directed vectors push expectations,
// a negedge monitor pops and compares on every done pulse.
module tb_mult_div_seq;
  import muldiv_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_seq_if bus ();

  mult_div_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   k;
  int   t;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending operation", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        $display("txn %s: cycle %0d hi=0x%08h lo=0x%08h div_zero=%0b", mon_e.name, cyc,
                 bus.hi_out, bus.lo_out, bus.div_zero);
        check({mon_e.name, "_hi"}, bus.hi_out, mon_e.hi);
        check({mon_e.name, "_lo"}, bus.lo_out, mon_e.lo);
        check({mon_e.name, "_dz"}, {31'b0, bus.div_zero}, {31'b0, mon_e.dz});
        check({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.cyc));
      end
    end else if (reset === 1'b1 && bus.div_zero === 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL stray_div_zero: got div_zero=1 with done=0 at cycle %0d, expected 0", cyc);
    end
  end

  task automatic do_start(input logic o, input logic [31:0] a, input logic [31:0] b, output int kk);
    @(negedge clk);
    bus.op    = o;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    kk = cyc;
  endtask

  task automatic push(input string nm, input logic [31:0] h, input logic [31:0] l,
                      input logic dz, input int c);
    exp_t e;
    e.name = nm;
    e.hi   = h;
    e.lo   = l;
    e.dz   = dz;
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input string nm);
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no done within %0d cycles, expected done", nm, w);
      sb_q.delete();
    end
    @(negedge clk);
    check({nm, "_busy_after"}, {31'b0, bus.busy}, 32'd0);
  endtask

  task automatic run_op(input string nm, input logic o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz, input int lat);
    int kk;
    do_start(o, a, b, kk);
    push(nm, eh, el, edz, kk + lat);
    wait_drain(nm);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    reset     = 1'b1;
    #1 reset  = 1'b0;
    #2;
    check("rst_hi", bus.hi_out, 32'h0);
    check("rst_lo", bus.lo_out, 32'h0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_dz", {31'b0, bus.div_zero}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // MULT 7 x -3 with a busy probe mid-run.
    do_start(OP_MULT, 32'd7, 32'hFFFF_FFFD, k);
    push("mul_7_m3", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, k + 32);
    repeat (3) @(negedge clk);
    check("mul_7_m3_busy_run", {31'b0, bus.busy}, 32'd1);
    check("mul_7_m3_done_run", {31'b0, bus.done}, 32'd0);
    wait_drain("mul_7_m3");

    run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32);
    run_op("div_100_0",  OP_DIV,  32'd100,       32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 0);
    run_op("mul_min_sq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 32);
    run_op("div_min_m1", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 32);
    run_op("div_7_m2",   OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 32);
    run_op("mul_m1_m1",  OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 32);
    run_op("div_max_min", OP_DIV, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 32);
    run_op("mul_big_16", OP_MULT, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 32);
    run_op("div_5_5",    OP_DIV,  32'd5,         32'd5,        32'h0000_0000, 32'h0000_0001, 1'b0, 32);

    // Starts during RUN and DONE must be ignored; operand changes must not matter.
    do_start(OP_MULT, 32'd6, 32'd7, k);
    push("mul_ignore", 32'h0, 32'd42, 1'b0, k + 32);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_DIV;
    bus.a_in  = 32'd9;
    bus.b_in  = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = OP_MULT;
    bus.a_in  = 32'd123;
    bus.b_in  = 32'd456;
    t = 0;
    while (bus.done !== 1'b1 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (bus.done !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL mul_ignore_timeout: got no done within %0d cycles, expected done", t);
    end
    bus.start = 1'b1;
    bus.a_in  = 32'd2;
    bus.b_in  = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    check("mul_ignore_busy_after", {31'b0, bus.busy}, 32'd0);
    check("mul_ignore_done_after", {31'b0, bus.done}, 32'd0);
    repeat (40) @(negedge clk);

    // Asynchronous reset mid-RUN aborts silently and clears results at once.
    do_start(OP_MULT, 32'd5, 32'd5, k);
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_hi", bus.hi_out, 32'h0);
    check("abort_lo", bus.lo_out, 32'h0);
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    run_op("mul_3_4", OP_MULT, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 32);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
